// File: rtl/sar_adc_pkg.sv
// SAR sequencer shared types: FSM state encoding and per-phase counter load values.
// Pure definitions; no latency, no flow control.
package sar_adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_SMP,
    ST_HOLD,
    ST_CS,
    ST_CONV,
    ST_DONE
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter load value on entry to a state; the phase ends when the counter reaches 0.
  function automatic int phase_len(input state_t s, input int t_rst, input int t_sample,
                                   input int n);
    case (s)
      ST_RST:  return t_rst - 1;
      ST_SMP:  return t_sample - 1;
      ST_CONV: return n - 1;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/sar_phase_cnt.sv
// Loadable down-counter with terminal-count flag; stops at zero instead of wrapping.
// Load takes effect on the next edge; no flow control.
module sar_phase_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR ADC sequencer: S/H pulse timing, N-bit binary search, dout with one-cycle valid.
// start-to-valid latency T_RST+T_SAMPLE+N+2 edges; start while busy is dropped, except in DONE.
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int N        = 8,
  parameter int T_RST    = 2,
  parameter int T_SAMPLE = 4,
  parameter bit AUTO     = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         comp_out,
  output logic         sample,
  output logic         snh_rst,
  output logic         cs_trigger,
  output logic [N-1:0] dac_code,
  output logic [N-1:0] dout,
  output logic         valid,
  output logic         busy
);

  localparam int CW = $clog2(max3(T_RST, T_SAMPLE, N) + 1);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("sar_adc_ctrl: N must be in 2..16");
  end
  if (T_RST < 1 || T_SAMPLE < 1) begin : g_bad_t
    $error("sar_adc_ctrl: T_RST and T_SAMPLE must be >= 1");
  end

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic          tc;
  logic [N-1:0]  res;
  logic [N-1:0]  bit_mask;
  logic [N-1:0]  res_upd;
  logic          comp_bit;

  // An unknown comparator decision resolves to 0.
  assign comp_bit = (comp_out === 1'b1);
  // During CONV the counter value is the index of the bit under trial.
  assign bit_mask = N'(1) << cnt;
  assign res_upd  = comp_bit ? (res | bit_mask) : (res & ~bit_mask);

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (start) nxt = ST_RST;
      ST_RST:  if (tc) nxt = ST_SMP;
      ST_SMP:  if (tc) nxt = ST_HOLD;
      ST_HOLD: nxt = ST_CS;
      ST_CS:   nxt = ST_CONV;
      ST_CONV: if (tc) nxt = ST_DONE;
      ST_DONE: nxt = (AUTO || start) ? ST_RST : ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  sar_phase_cnt #(.W(CW)) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (nxt != state),
    .load_val (CW'(phase_len(nxt, T_RST, T_SAMPLE, N))),
    .cnt      (cnt),
    .tc       (tc)
  );

  // Outputs are registered from the next state so each pulse lines up with its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      sample     <= 1'b0;
      snh_rst    <= 1'b0;
      cs_trigger <= 1'b0;
      dac_code   <= '0;
      dout       <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      res        <= '0;
    end else begin
      state      <= nxt;
      snh_rst    <= (nxt == ST_RST);
      sample     <= (nxt == ST_SMP);
      cs_trigger <= (nxt == ST_CS);
      valid      <= (nxt == ST_DONE);
      busy       <= (nxt != ST_IDLE);
      dac_code   <= '0;
      if (state == ST_CONV) begin
        res <= res_upd;
        if (nxt == ST_CONV) begin
          dac_code <= res_upd | (bit_mask >> 1);
        end else begin
          dout <= res_upd;
        end
      end else if (nxt == ST_CONV) begin
        res      <= '0;
        dac_code <= {1'b1, {(N-1){1'b0}}};
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(sample && snh_rst));
      if (state == ST_CONV) assert (!$isunknown(comp_out));
    end
  end
`endif

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: an ideal comparator on a random input voltage, whose
// converted value must equal that voltage, plus a timing model of every output per edge.
module tb_sar_adc_ctrl;

  localparam int NB = 8;
  localparam int TR = 2;
  localparam int TS = 4;
  localparam int KV = TR + TS + NB + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, start_a;
  logic          comp_out, comp_a;
  logic          sample, snh_rst, cs_trigger, valid, busy;
  logic          sample_a, snh_rst_a, cs_trigger_a, valid_a, busy_a;
  logic [NB-1:0] dac_code, dout, dac_code_a, dout_a;
  logic [7:0]    vin, vin_a, prev_dout;
  logic [1:0]    cmode;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  // cmode 0: ideal comparator vin >= dac; 1: stuck high; 2: stuck low.
  always_comb begin
    comp_out = (cmode == 2'd1) ? 1'b1 : (cmode == 2'd2) ? 1'b0 : (vin >= dac_code);
    comp_a   = (vin_a >= dac_code_a);
  end

  sar_adc_ctrl #(.N(NB), .T_RST(TR), .T_SAMPLE(TS), .AUTO(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .comp_out(comp_out),
    .sample(sample), .snh_rst(snh_rst), .cs_trigger(cs_trigger),
    .dac_code(dac_code), .dout(dout), .valid(valid), .busy(busy)
  );

  sar_adc_ctrl #(.N(NB), .T_RST(TR), .T_SAMPLE(TS), .AUTO(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .comp_out(comp_a),
    .sample(sample_a), .snh_rst(snh_rst_a), .cs_trigger(cs_trigger_a),
    .dac_code(dac_code_a), .dout(dout_a), .valid(valid_a), .busy(busy_a)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Binary-search trial j: bits above the trial taken from the answer, trial bit set.
  function automatic logic [7:0] trial(input logic [7:0] v, input int j);
    logic [7:0] ones, hi;
    ones = 8'hFF;
    hi   = ~(ones >> j);
    return (v & hi) | (8'h80 >> j);
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, ".snh_rst"}, snh_rst, 0);
    chk({tag, ".sample"}, sample, 0);
    chk({tag, ".cs_trigger"}, cs_trigger, 0);
    chk({tag, ".dac_code"}, dac_code, 0);
    chk({tag, ".dout"}, dout, 0);
    chk({tag, ".valid"}, valid, 0);
    chk({tag, ".busy"}, busy, 0);
  endtask

  // Caller raises start first; edge k=0 is the acceptance edge.
  task automatic run_conv(input logic [7:0] v, input logic [1:0] mode, input int poke_a,
                          input int poke_b, input int abort_k, input bit restart);
    int j;
    vin   = v;
    cmode = mode;
    for (int k = 0; k <= KV; k++) begin
      step();
      j = k - (TR + TS + 2);
      chk($sformatf("snh_rst@%0d", k), snh_rst, k < TR);
      chk($sformatf("sample@%0d", k), sample, (k >= TR) && (k < TR + TS));
      chk($sformatf("cs_trigger@%0d", k), cs_trigger, k == TR + TS + 1);
      chk($sformatf("valid@%0d", k), valid, k == KV);
      chk($sformatf("busy@%0d", k), busy, 1);
      chk($sformatf("dac_code@%0d", k), dac_code, (j >= 0 && j < NB) ? trial(v, j) : 8'h00);
      chk($sformatf("dout@%0d", k), dout, (k == KV) ? v : prev_dout);
      start = (k == poke_a) || (k == poke_b) || (restart && k == KV);
      if (k == abort_k) begin
        start = 1'b0;
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        step();
        chk_zero("in_rst");
        rst = 1'b0;
        prev_dout = 8'h00;
        return;
      end
    end
    prev_dout = v;
    if (!restart) begin
      step();
      chk("idle.busy", busy, 0);
      chk("idle.valid", valid, 0);
      chk("idle.dac_code", dac_code, 0);
      chk("idle.dout", dout, v);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert (!(sample && snh_rst) && !(sample_a && snh_rst_a)) else begin
        errors++;
        $error("FAIL snh_overlap observed=%0b%0b%0b%0b expected=no pair high",
               sample, snh_rst, sample_a, snh_rst_a);
      end
    end
  end

  initial begin
    int nv, e, last_e;
    rst = 1'b1; start = 1'b0; start_a = 1'b0; cmode = 2'd0;
    vin = 8'h00; vin_a = 8'h00; prev_dout = 8'h00;
    step();
    step();
    chk_zero("reset");
    rst = 1'b0;
    repeat (7) step();

    // Directed pattern 1,0,1,1,0,0,1,0 comes from an input of 0xB2.
    start = 1'b1; run_conv(8'hB2, 2'd0, -1, -1, -1, 1'b0);
    start = 1'b1; run_conv(8'hFF, 2'd1, -1, -1, -1, 1'b0);
    start = 1'b1; run_conv(8'h00, 2'd2, -1, -1, -1, 1'b0);

    // start during SMP and CONV is dropped and must not queue.
    start = 1'b1; run_conv(8'($urandom_range(0, 255)), 2'd0, 3, 10, -1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("no_queue.busy%0d", i), busy, 0);
    end

    // Reset while bit 4 is under trial, then a clean conversion.
    start = 1'b1; run_conv(8'($urandom_range(0, 255)), 2'd0, -1, -1, 11, 1'b0);
    step();
    chk("post_rst.busy", busy, 0);
    start = 1'b1; run_conv(8'($urandom_range(0, 255)), 2'd0, -1, -1, -1, 1'b0);

    // start held in DONE restarts straight into RST.
    start = 1'b1; run_conv(8'($urandom_range(0, 255)), 2'd0, -1, -1, -1, 1'b1);
    run_conv(8'($urandom_range(0, 255)), 2'd0, -1, -1, -1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      start = 1'b1; run_conv(8'($urandom_range(0, 255)), 2'd0, -1, -1, -1, 1'b0);
    end

    // Free-running instance: one start, then a valid every 17 edges.
    vin_a = 8'($urandom_range(0, 255));
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    nv = 0; e = 0; last_e = -1;
    while (nv < 4 && e < 200) begin
      step();
      e++;
      if (valid_a) begin
        chk($sformatf("auto.interval%0d", nv), e - last_e, (nv == 0) ? KV + 1 : KV + 1);
        chk($sformatf("auto.dout%0d", nv), dout_a, vin_a);
        chk($sformatf("auto.busy%0d", nv), busy_a, 1);
        last_e = e;
        vin_a = 8'($urandom_range(0, 255));
        nv++;
      end
    end
    chk("auto.valid_count", nv, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
